// File: rtl/cc_logic_arbiter_if.sv
// rtl/cc_logic_arbiter_if.sv - requester and result handshake bundle for cc_logic_arbiter
// Optional zero-flag signal present when CC_LOGICARB_ZEROFLAG_EN is defined.
interface cc_logic_arbiter_if #(
  parameter int NUMBER_DATAWIDTH = 8
);
  logic                        CC_LOGICARB_req0Valid_In;
  logic                        CC_LOGICARB_req0Ready_Out;
  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICARB_req0Data0_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICARB_req0Data1_In;
  logic [1:0]                  CC_LOGICARB_req0Op_In;
  logic                        CC_LOGICARB_req1Valid_In;
  logic                        CC_LOGICARB_req1Ready_Out;
  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICARB_req1Data0_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICARB_req1Data1_In;
  logic [1:0]                  CC_LOGICARB_req1Op_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICARB_z_Out;
  logic                        CC_LOGICARB_zValid_Out;
  logic                        CC_LOGICARB_zId_Out;
  logic                        CC_LOGICARB_zReady_In;
`ifdef CC_LOGICARB_ZEROFLAG_EN
  logic                        CC_LOGICARB_zZero_Out;
`endif

  modport master (
    output CC_LOGICARB_req0Valid_In, CC_LOGICARB_req0Data0_In, CC_LOGICARB_req0Data1_In,
    output CC_LOGICARB_req0Op_In,
    output CC_LOGICARB_req1Valid_In, CC_LOGICARB_req1Data0_In, CC_LOGICARB_req1Data1_In,
    output CC_LOGICARB_req1Op_In,
    output CC_LOGICARB_zReady_In,
    input  CC_LOGICARB_req0Ready_Out, CC_LOGICARB_req1Ready_Out,
`ifdef CC_LOGICARB_ZEROFLAG_EN
    input  CC_LOGICARB_zZero_Out,
`endif
    input  CC_LOGICARB_z_Out, CC_LOGICARB_zValid_Out, CC_LOGICARB_zId_Out
  );

  modport slave (
    input  CC_LOGICARB_req0Valid_In, CC_LOGICARB_req0Data0_In, CC_LOGICARB_req0Data1_In,
    input  CC_LOGICARB_req0Op_In,
    input  CC_LOGICARB_req1Valid_In, CC_LOGICARB_req1Data0_In, CC_LOGICARB_req1Data1_In,
    input  CC_LOGICARB_req1Op_In,
    input  CC_LOGICARB_zReady_In,
    output CC_LOGICARB_req0Ready_Out, CC_LOGICARB_req1Ready_Out,
`ifdef CC_LOGICARB_ZEROFLAG_EN
    output CC_LOGICARB_zZero_Out,
`endif
    output CC_LOGICARB_z_Out, CC_LOGICARB_zValid_Out, CC_LOGICARB_zId_Out
  );
endinterface

// File: rtl/cc_logic_arbiter.sv
// rtl/cc_logic_arbiter.sv - round-robin arbiter sharing one bitwise logic unit between two requesters
// Optional zero-flag output enabled by defining CC_LOGICARB_ZEROFLAG_EN.
module cc_logic_arbiter #(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input  logic               CC_LOGICARB_CLOCK_50,
  input  logic               CC_LOGICARB_RESET_InLow,
  cc_logic_arbiter_if.slave  bus
);
  localparam int W = NUMBER_DATAWIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           prio;
  logic           any_req;
  logic           grant_id;
  logic           accept;
  logic           ready0, ready1;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic           id_q;
  logic [W-1:0]   result;
  logic [W-1:0]   z_q;
  logic           zvalid_q;
  logic           zid_q;
`ifdef CC_LOGICARB_ZEROFLAG_EN
  logic           zzero_q;
`endif

  // A lone requester wins regardless of the pointer; prio only breaks ties.
  assign any_req  = bus.CC_LOGICARB_req0Valid_In | bus.CC_LOGICARB_req1Valid_In;
  assign grant_id = (bus.CC_LOGICARB_req0Valid_In & bus.CC_LOGICARB_req1Valid_In)
                    ? prio : bus.CC_LOGICARB_req1Valid_In;

  always_ff @(posedge CC_LOGICARB_CLOCK_50) begin
    if (!CC_LOGICARB_RESET_InLow) state <= IDLE;
    else                          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && CC_LOGICARB_RESET_InLow) begin
          accept    = 1'b1;
          ready0    = ~grant_id;
          ready1    = grant_id;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.CC_LOGICARB_zReady_In) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_q)
      2'b00: result = a_q | b_q;
      2'b01: result = a_q & b_q;
      2'b10: result = a_q ^ b_q;
      2'b11: result = ~(a_q | b_q);
      default: result = '0;
    endcase
  end

  always_ff @(posedge CC_LOGICARB_CLOCK_50) begin
    if (!CC_LOGICARB_RESET_InLow) begin
      prio     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      id_q     <= 1'b0;
      z_q      <= '0;
      zvalid_q <= 1'b0;
      zid_q    <= 1'b0;
`ifdef CC_LOGICARB_ZEROFLAG_EN
      zzero_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q  <= grant_id ? bus.CC_LOGICARB_req1Data0_In : bus.CC_LOGICARB_req0Data0_In;
        b_q  <= grant_id ? bus.CC_LOGICARB_req1Data1_In : bus.CC_LOGICARB_req0Data1_In;
        op_q <= grant_id ? bus.CC_LOGICARB_req1Op_In    : bus.CC_LOGICARB_req0Op_In;
        id_q <= grant_id;
      end
      if (state == EXEC) begin
        z_q      <= result;
        zvalid_q <= 1'b1;
        zid_q    <= id_q;
`ifdef CC_LOGICARB_ZEROFLAG_EN
        zzero_q  <= (result == '0);
`endif
      end
      // Retirement hands the tie-break to the requester that was not just served.
      if (state == RESP && bus.CC_LOGICARB_zReady_In) begin
        zvalid_q <= 1'b0;
        prio     <= ~zid_q;
      end
    end
  end

  assign bus.CC_LOGICARB_req0Ready_Out = ready0;
  assign bus.CC_LOGICARB_req1Ready_Out = ready1;
  assign bus.CC_LOGICARB_z_Out         = z_q;
  assign bus.CC_LOGICARB_zValid_Out    = zvalid_q;
  assign bus.CC_LOGICARB_zId_Out       = zid_q;
`ifdef CC_LOGICARB_ZEROFLAG_EN
  assign bus.CC_LOGICARB_zZero_Out     = zzero_q;
`endif
endmodule

// File: tb/tb_cc_logic_arbiter.sv
// tb/tb_cc_logic_arbiter.sv - directed vector bench for cc_logic_arbiter
// Zero-flag checks compiled in when CC_LOGICARB_ZEROFLAG_EN is defined.
module tb_cc_logic_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    bit         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp_z;
    bit         exp_zero;
  } vec_t;

  vec_t vecs[8];

  cc_logic_arbiter_if #(.NUMBER_DATAWIDTH(8)) bus ();

  cc_logic_arbiter #(.NUMBER_DATAWIDTH(8)) dut (
    .CC_LOGICARB_CLOCK_50    (clk),
    .CC_LOGICARB_RESET_InLow (resetn),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    if (r == 1'b0) begin
      bus.CC_LOGICARB_req0Valid_In = v;
      bus.CC_LOGICARB_req0Data0_In = a;
      bus.CC_LOGICARB_req0Data1_In = b;
      bus.CC_LOGICARB_req0Op_In    = op;
    end else begin
      bus.CC_LOGICARB_req1Valid_In = v;
      bus.CC_LOGICARB_req1Data0_In = a;
      bus.CC_LOGICARB_req1Data1_In = b;
      bus.CC_LOGICARB_req1Op_In    = op;
    end
  endtask

  // Returns at the falling edge of the grant cycle; id=-1 on timeout.
  task automatic wait_grant(input string name, output int id);
    id = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.CC_LOGICARB_req0Ready_Out || bus.CC_LOGICARB_req1Ready_Out) begin
        chk({name, "_ready_excl"},
            {31'd0, bus.CC_LOGICARB_req0Ready_Out & bus.CC_LOGICARB_req1Ready_Out}, 32'd0);
        id = bus.CC_LOGICARB_req1Ready_Out ? 1 : 0;
        break;
      end
    end
    if (id < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no grant within 20 cycles, expected a ready pulse", name);
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] exp_z, input bit exp_id);
    chk({name, "_zvalid"}, {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd1);
    chk({name, "_z"},      {24'd0, bus.CC_LOGICARB_z_Out}, {24'd0, exp_z});
    chk({name, "_zid"},    {31'd0, bus.CC_LOGICARB_zId_Out}, {31'd0, exp_id});
`ifdef CC_LOGICARB_ZEROFLAG_EN
    chk({name, "_zzero"},  {31'd0, bus.CC_LOGICARB_zZero_Out}, {31'd0, exp_z == 8'h00});
`endif
  endtask

  // Full single-request operation with zReady high: grant at N, zValid at N+2.
  task automatic do_op(input string name, input bit r, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp_z);
    int id;
    set_req(r, 1'b1, a, b, op);
    wait_grant(name, id);
    chk({name, "_grant"}, id, {31'd0, r});
    @(posedge clk); #1;
    set_req(r, 1'b0, a, b, op);
    @(negedge clk);
    chk({name, "_n1_zvalid"}, {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd0);
    @(negedge clk);
    check_result(name, exp_z, r);
    @(posedge clk); #1;
  endtask

  initial begin
    int id;
    vecs[0] = '{1'b0, 8'hF0, 8'h0F, 2'b00, 8'hFF, 1'b0};
    vecs[1] = '{1'b1, 8'hAA, 8'h55, 2'b10, 8'hFF, 1'b0};
    vecs[2] = '{1'b0, 8'hCC, 8'hAA, 2'b01, 8'h88, 1'b0};
    vecs[3] = '{1'b1, 8'h3C, 8'h0F, 2'b11, 8'hC0, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 2'b11, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'h12, 8'h34, 2'b01, 8'h10, 1'b0};
    vecs[6] = '{1'b0, 8'h5A, 8'hA5, 2'b10, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1};

    // Reset with both requesters already pending: nothing may be granted yet.
    resetn = 1'b0;
    bus.CC_LOGICARB_zReady_In = 1'b1;
    set_req(1'b0, 1'b1, 8'hC3, 8'h0C, 2'b00);
    set_req(1'b1, 1'b1, 8'hAA, 8'h55, 2'b10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, bus.CC_LOGICARB_req0Ready_Out}, 32'd0);
    chk("rst_ready1", {31'd0, bus.CC_LOGICARB_req1Ready_Out}, 32'd0);
    chk("rst_zvalid", {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd0);
    chk("rst_z",      {24'd0, bus.CC_LOGICARB_z_Out}, 32'd0);
    chk("rst_zid",    {31'd0, bus.CC_LOGICARB_zId_Out}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Contention from reset and fairness: grants alternate starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      wait_grant("fair", id);
      chk("fair_grant", id, i % 2);
      @(posedge clk); #1;
      if (i == 5) begin
        set_req(1'b0, 1'b0, 8'hC3, 8'h0C, 2'b00);
        set_req(1'b1, 1'b0, 8'hAA, 8'h55, 2'b10);
      end
      @(negedge clk);
      @(negedge clk);
      check_result("fair", (i % 2 == 1) ? 8'hFF : 8'hCF, i[0]);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_z);

    // Backpressure: result held while zReady low, requester 1 waits.
    bus.CC_LOGICARB_zReady_In = 1'b0;
    set_req(1'b0, 1'b1, 8'hCC, 8'hAA, 2'b01);
    set_req(1'b1, 1'b1, 8'h0F, 8'hF0, 2'b00);
    wait_grant("bp", id);
    chk("bp_grant", id, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'hCC, 8'hAA, 2'b01);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_result("bp_stall", 8'h88, 1'b0);
      chk("bp_no_ready",
          {31'd0, bus.CC_LOGICARB_req0Ready_Out | bus.CC_LOGICARB_req1Ready_Out}, 32'd0);
      @(negedge clk);
    end
    bus.CC_LOGICARB_zReady_In = 1'b1;
    chk("bp_retire_cycle_zvalid", {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd1);
    @(negedge clk);
    chk("bp_retired",   {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd0);
    chk("bp_next_req1", {31'd0, bus.CC_LOGICARB_req1Ready_Out}, 32'd1);
    chk("bp_next_req0", {31'd0, bus.CC_LOGICARB_req0Ready_Out}, 32'd0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 8'h0F, 8'hF0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_result("bp_second", 8'hFF, 1'b1);
    @(posedge clk); #1;

    // Leave prio at 1, then reset while the next operation is in EXEC.
    do_op("pre_rst", 1'b0, 8'h01, 8'h02, 2'b00, 8'h03);
    set_req(1'b0, 1'b1, 8'hF0, 8'h0F, 2'b00);
    wait_grant("midrst", id);
    chk("midrst_grant", id, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'hF0, 8'h0F, 2'b00);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_zvalid", {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd0);
    chk("midrst_z",      {24'd0, bus.CC_LOGICARB_z_Out}, 32'd0);
    chk("midrst_zid",    {31'd0, bus.CC_LOGICARB_zId_Out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, bus.CC_LOGICARB_zValid_Out}, 32'd0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 8'h11, 8'h22, 2'b00);
    set_req(1'b1, 1'b1, 8'h44, 8'h0F, 2'b01);
    wait_grant("midrst_prio", id);
    chk("midrst_prio_grant", id, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'h11, 8'h22, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_result("midrst_after0", 8'h33, 1'b0);
    @(posedge clk); #1;
    wait_grant("midrst_after1", id);
    chk("midrst_after1_grant", id, 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 8'h44, 8'h0F, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check_result("midrst_after1", 8'h04, 1'b1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
